fir_stream_scheduler: RTL and testbench

// - Shares the single 15-tap FIR datapath between NUM_CH AXI-Stream requesters, one whole frame at a time.
// - Frames are bounded by tlast. Grants are round-robin.
// - After each frame it appends FLUSH_LEN zero beats to drain the FIR pipeline, so frames never mix.
// - The last flush beat carries tlast. Every beat is tagged with its channel ID on m00_axis_tuser.
// - Sits between the ADC/DDC channel streams and the FIR s00_axis port.

---
 rtl/fir_sched_pkg.sv | 30 +++
 rtl/fir_stream_scheduler_rr_arbiter.sv | 26 ++
 rtl/fir_stream_scheduler.sv | 124 ++++++++++++
 tb/tb_fir_stream_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// Shared types, constants and the round-robin pick helper for the FIR stream scheduler.
package fir_sched_pkg;

  typedef enum logic [1:0] {ARB, STREAM, FLUSH, DRAIN} sched_state_t;

  localparam int unsigned FIR_TAPS = 15;
  localparam int unsigned MAX_CH   = 8;

  // First requester at or above ptr, wrapping modulo num_ch; 0 when nothing requests.
  function automatic int unsigned rr_pick(input logic [MAX_CH-1:0] req,
                                          input logic [2:0]        ptr,
                                          input int unsigned       num_ch);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      if (k < num_ch) begin
        idx = (ptr + k) % num_ch;
        if (!found && req[idx[2:0]]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fir_stream_scheduler_rr_arbiter.sv
// Combinational round-robin pick over NUM_CH requesters.
module rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   gnt,
  output logic              any_req
);

  logic [MAX_CH-1:0] req_ext;
  logic [2:0]        ptr_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_CH-1:0]  = req;
    ptr_ext              = '0;
    ptr_ext[CH_W-1:0]    = ptr;
    gnt                  = CH_W'(rr_pick(req_ext, ptr_ext, NUM_CH));
    any_req              = |req;
  end

endmodule

// File: rtl/fir_stream_scheduler.sv
// Shares one FIR datapath between NUM_CH AXI-Stream channels a frame at a time,
// appending FLUSH_LEN zero beats after each frame so the FIR pipeline drains cleanly.
module fir_stream_scheduler
  import fir_sched_pkg::*;
#(
  parameter  int unsigned NUM_CH    = 4,
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned FLUSH_LEN = FIR_TAPS,
  parameter  int unsigned MAX_FRAME = 4096,
  localparam int unsigned CH_W      = $clog2(NUM_CH)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m00_axis_tdata,
  output logic                     m00_axis_tvalid,
  output logic                     m00_axis_tlast,
  output logic [CH_W-1:0]          m00_axis_tuser,
  input  logic                     m00_axis_tready,
  output logic                     frame_trunc
);

  localparam int unsigned BC_W = $clog2(MAX_FRAME + 1);
  localparam int unsigned FC_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT  = BC_W'(MAX_FRAME - 1);
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_LEN - 1);
  localparam logic [CH_W-1:0] CH_LAST    = CH_W'(NUM_CH - 1);

  sched_state_t      state;
  logic [CH_W-1:0]   gnt;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   pick;
  logic              any_req;
  logic [BC_W-1:0]   beat_cnt;
  logic [FC_W-1:0]   flush_cnt;
  logic              load_ok;
  logic              accept;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req     (s_axis_tvalid),
    .ptr     (rr_ptr),
    .gnt     (pick),
    .any_req (any_req)
  );

  always_comb begin
    load_ok       = !m00_axis_tvalid || m00_axis_tready;
    in_data       = s_axis_tdata[gnt*DATA_W +: DATA_W];
    in_last       = s_axis_tlast[gnt];
    s_axis_tready = '0;
    if (state == STREAM) s_axis_tready[gnt] = load_ok;
    accept        = (state == STREAM) && s_axis_tvalid[gnt] && load_ok;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state           <= ARB;
      gnt             <= '0;
      rr_ptr          <= '0;
      beat_cnt        <= '0;
      flush_cnt       <= '0;
      m00_axis_tdata  <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tuser  <= '0;
      frame_trunc     <= 1'b0;
    end else begin
      frame_trunc <= 1'b0;
      // A consumed beat retires here; any load below in the same cycle overrides it.
      if (m00_axis_tvalid && m00_axis_tready) begin
        m00_axis_tvalid <= 1'b0;
        m00_axis_tlast  <= 1'b0;
      end
      case (state)
        ARB: begin
          if (any_req) begin
            gnt   <= pick;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            m00_axis_tdata  <= in_data;
            m00_axis_tvalid <= 1'b1;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tuser  <= gnt;
            beat_cnt        <= beat_cnt + 1'b1;
            if (in_last) begin
              state <= FLUSH;
            end else if (beat_cnt == LAST_BEAT) begin
              state       <= FLUSH;
              frame_trunc <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (load_ok) begin
            m00_axis_tdata  <= '0;
            m00_axis_tvalid <= 1'b1;
            m00_axis_tuser  <= gnt;
            m00_axis_tlast  <= (flush_cnt == FLUSH_LAST);
            flush_cnt       <= flush_cnt + 1'b1;
            if (flush_cnt == FLUSH_LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (m00_axis_tvalid && m00_axis_tready) begin
            rr_ptr    <= (gnt == CH_LAST) ? '0 : gnt + 1'b1;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            state     <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_scheduler.sv
// Directed self-checking bench for fir_stream_scheduler (4 channels, MAX_FRAME=8).
module tb_fir_stream_scheduler;

  localparam int NCH = 4;
  localparam int FL  = 15;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int unsigned gap;
  } src_beat_t;

  logic            aclk = 1'b0;
  logic            areset;
  logic [NCH*32-1:0] s_tdata;
  logic [NCH-1:0]  s_tvalid;
  logic [NCH-1:0]  s_tlast;
  logic [NCH-1:0]  s_tready;
  logic [31:0]     m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic [1:0]      m_tuser;
  logic            m_tready;
  logic            frame_trunc;

  int checks = 0;
  int errors = 0;

  src_beat_t   src_q[NCH][$];
  logic [34:0] outq[$];
  logic [NCH-1:0] acc;
  logic [NCH-1:0] loaded;
  int unsigned gapc[NCH];
  int unsigned drv_cyc = 0;
  int          rdy_mode = 0;

  int unsigned cyc = 0;
  int          trunc_cnt = 0;
  int          onehot_viol = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [34:0] prev_beat = '0;
  logic        arm = 1'b0;
  int unsigned first1 = 0;
  int unsigned ch0_done = 0;

  always #5 aclk = ~aclk;

  fir_stream_scheduler #(
    .NUM_CH    (NCH),
    .DATA_W    (32),
    .FLUSH_LEN (FL),
    .MAX_FRAME (8)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .s_axis_tdata    (s_tdata),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tlast    (s_tlast),
    .s_axis_tready   (s_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tuser  (m_tuser),
    .m00_axis_tready (m_tready),
    .frame_trunc     (frame_trunc)
  );

  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int ch, input int n, input logic [31:0] base,
                            input int gap_at, input int unsigned gap_len);
    for (int i = 0; i < n; i++) begin
      src_beat_t b;
      b.data = base + 32'(i);
      b.last = (i == n - 1);
      b.gap  = (i == gap_at) ? gap_len : 0;
      src_q[ch].push_back(b);
    end
  endtask

  // Expected frame: n data beats base..base+n-1, then FL zeros, tlast on the final beat only.
  task automatic check_frame(input string tag, input int ch, input int n, input logic [31:0] base);
    int unsigned waited = 0;
    logic [34:0] e;
    while (outq.size() < n + FL && waited < 400) begin
      step();
      waited++;
    end
    if (outq.size() < n + FL) begin
      chk({tag, "_timeout"}, 64'(outq.size()), 64'(n + FL));
      return;
    end
    for (int i = 0; i < n + FL; i++) begin
      e[31:0]  = (i < n) ? base + 32'(i) : 32'h0;
      e[33:32] = 2'(ch);
      e[34]    = (i == n + FL - 1);
      chk($sformatf("%s_beat%0d", tag, i), 64'(outq.pop_front()), 64'(e));
    end
  endtask

  // Source driver: presents queued beats per channel, pops on handshake.
  initial begin
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    loaded   = '0;
    acc      = '0;
    for (int c = 0; c < NCH; c++) gapc[c] = 0;
    forever begin
      @(negedge aclk);
      acc = s_tvalid & s_tready;
      @(posedge aclk);
      #1;
      drv_cyc++;
      for (int c = 0; c < NCH; c++) begin
        if (acc[c]) begin
          src_q[c].delete(0);
          loaded[c] = 1'b0;
        end
        if (!loaded[c] && src_q[c].size() > 0) begin
          gapc[c]   = src_q[c][0].gap;
          loaded[c] = 1'b1;
        end else if (gapc[c] > 0) begin
          gapc[c]--;
        end
        s_tvalid[c] = loaded[c] && (gapc[c] == 0);
        s_tdata[c*32 +: 32] = loaded[c] ? src_q[c][0].data : 32'h0;
        s_tlast[c] = loaded[c] ? src_q[c][0].last : 1'b0;
      end
      m_tready = (rdy_mode == 0) ? 1'b1 : ((drv_cyc % 4 == 0) || (drv_cyc % 4 == 3));
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge aclk);
      cyc++;
      if (m_tvalid && m_tready) outq.push_back({m_tlast, m_tuser, m_tdata});
      if (frame_trunc) trunc_cnt++;
      if ($countones(s_tready) > 1) onehot_viol++;
      if (prev_stall && !areset && !(m_tvalid && ({m_tlast, m_tuser, m_tdata} == prev_beat)))
        stall_viol++;
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tlast, m_tuser, m_tdata};
      if (!arm) begin
        first1   = 0;
        ch0_done = 0;
      end else begin
        if (s_tready[1] && first1 == 0) first1 = cyc;
        if (m_tvalid && m_tready && m_tlast && m_tuser == 2'd0 && ch0_done == 0) ch0_done = cyc;
      end
    end
  end

  initial begin
    areset = 1'b1;
    repeat (3) step();
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata",  64'(m_tdata),  64'd0);
    chk("rst_tlast",  64'(m_tlast),  64'd0);
    chk("rst_tuser",  64'(m_tuser),  64'd0);
    chk("rst_trunc",  64'(frame_trunc), 64'd0);
    chk("rst_sready", 64'(s_tready), 64'd0);
    @(negedge aclk);
    areset = 1'b0;

    // Single 4-beat frame on channel 0
    push_frame(0, 4, 32'd1, -1, 0);
    check_frame("t1_ch0", 0, 4, 32'd1);

    // Channels 1 and 3 pending at reset release
    step();
    areset = 1'b1;
    push_frame(1, 2, 32'h100, -1, 0);
    push_frame(3, 2, 32'h300, -1, 0);
    repeat (2) step();
    areset = 1'b0;
    check_frame("t2_ch1", 1, 2, 32'h100);
    check_frame("t2_ch3", 3, 2, 32'h300);

    // All channels requesting: order 0,1,2,3,0
    push_frame(0, 1, 32'hA0, -1, 0);
    push_frame(1, 1, 32'hA1, -1, 0);
    push_frame(2, 1, 32'hA2, -1, 0);
    push_frame(3, 1, 32'hA3, -1, 0);
    push_frame(0, 1, 32'hA4, -1, 0);
    check_frame("t2_rr0", 0, 1, 32'hA0);
    check_frame("t2_rr1", 1, 1, 32'hA1);
    check_frame("t2_rr2", 2, 1, 32'hA2);
    check_frame("t2_rr3", 3, 1, 32'hA3);
    check_frame("t2_rr4", 0, 1, 32'hA4);

    // Downstream backpressure 1,0,0,1
    rdy_mode = 1;
    push_frame(2, 4, 32'h10, -1, 0);
    check_frame("t3_bp", 2, 4, 32'h10);
    rdy_mode = 0;
    chk("t3_hold_stable", 64'(stall_viol), 64'd0);

    // 10-beat frame cut at MAX_FRAME=8
    push_frame(2, 10, 32'h20, -1, 0);
    check_frame("t4_first", 2, 8, 32'h20);
    check_frame("t4_rest", 2, 2, 32'h28);
    chk("t4_trunc_cnt", 64'(trunc_cnt), 64'd1);

    // Channel 0 stalls mid-frame while channel 1 waits
    arm = 1'b1;
    push_frame(0, 5, 32'hC0, 2, 20);
    push_frame(1, 2, 32'hD0, -1, 0);
    check_frame("t5_ch0", 0, 5, 32'hC0);
    check_frame("t5_ch1", 1, 2, 32'hD0);
    chk("t5_ch0_done_seen", 64'(ch0_done != 0), 64'd1);
    chk("t5_ch1_after_ch0", 64'(first1 > ch0_done), 64'd1);
    arm = 1'b0;

    // Reset during FLUSH with flush_cnt=5
    push_frame(1, 1, 32'h55, -1, 0);
    begin
      int unsigned w = 0;
      while (outq.size() < 6 && w < 200) begin
        step();
        w++;
      end
    end
    chk("t6_reached_flush", 64'(outq.size()), 64'd6);
    areset = 1'b1;
    #1;
    chk("t6_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_tuser",  64'(m_tuser),  64'd0);
    chk("t6_tlast",  64'(m_tlast),  64'd0);
    chk("t6_tdata",  64'(m_tdata),  64'd0);
    chk("t6_sready", 64'(s_tready), 64'd0);
    @(negedge aclk);
    areset = 1'b0;
    outq.delete();
    push_frame(2, 2, 32'hE0, -1, 0);
    push_frame(0, 1, 32'hF0, -1, 0);
    check_frame("t6_ch0", 0, 1, 32'hF0);
    check_frame("t6_ch2", 2, 2, 32'hE0);

    chk("onehot_sready", 64'(onehot_viol), 64'd0);
    chk("final_trunc_cnt", 64'(trunc_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
